// File: rtl/snake_pkg.sv
// Shared constants for the snake body streamer: direction encodings, grid defaults, sentinel.
// Optional self-collision logic is enabled with the SNAKE_SELF_COLLISION_EN macro.
package snake_pkg;

  localparam int COORD_W = 7;
  localparam logic [COORD_W-1:0] SENTINEL = 7'h7F;

  localparam int GRID_X_BLOCKS = 124;
  localparam int GRID_Y_BLOCKS = 81;
  localparam int GRID_START_X  = 62;
  localparam int GRID_START_Y  = 40;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  // Opposite direction differs only in the low bit (up<->down, right<->left).
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_collision_check.sv
// Comparator bank: flags when the proposed head lands on any body entry except the tail,
// which vacates on the same move. Instantiated only with SNAKE_SELF_COLLISION_EN.
module snake_collision_check
  import snake_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int LEN_W = 5
) (
  input  logic [COORD_W-1:0]            next_x,
  input  logic [COORD_W-1:0]            next_y,
  input  logic [DEPTH-1:0][COORD_W-1:0] body_x,
  input  logic [DEPTH-1:0][COORD_W-1:0] body_y,
  input  logic [LEN_W-1:0]              snake_length,
  output logic                          hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((LEN_W'(i) + LEN_W'(2) < snake_length) &&
          (body_x[i] == next_x) && (body_y[i] == next_y)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake position store: one-cycle body shift per move, growth, wall/self game-over, and a
// free-running body_count that streams one body entry per cycle. Macro: SNAKE_SELF_COLLISION_EN.
module snake_body_streamer
  import snake_pkg::*;
#(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int X_BLOCKS         = GRID_X_BLOCKS,
  parameter int Y_BLOCKS         = GRID_Y_BLOCKS,
  parameter int START_X          = GRID_START_X,
  parameter int START_Y          = GRID_START_Y
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        move_tick,
  input  logic [1:0]                  direction,
  input  logic                        grow,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [SNAKE_LENGTH_BIT:0]   snake_length,
  output logic                        game_over
);

  localparam int DEPTH = SNAKE_LENGTH_MAX - 1;
  localparam int LEN_W = SNAKE_LENGTH_BIT + 1;

  typedef logic [DEPTH-1:0][COORD_W-1:0] body_t;

  logic [COORD_W-1:0]          head_x_q, head_x_d, head_y_q, head_y_d;
  body_t                       body_x_q, body_x_d, body_y_q, body_y_d;
  logic [LEN_W-1:0]            len_q, len_d;
  dir_e                        dir_q, dir_d;
  logic                        grow_pend_q, grow_pend_d;
  logic                        game_over_q, game_over_d;
  logic [SNAKE_LENGTH_BIT-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0]          out_x_q, out_x_d, out_y_q, out_y_d;

  dir_e               eff_dir;
  logic [COORD_W-1:0] next_x, next_y;
  logic               wall_hit, self_hit, grow_now;

  // Candidate head position and wall test for the direction this move would take.
  always_comb begin
    eff_dir  = (dir_e'(direction) == reverse_dir(dir_q)) ? dir_q : dir_e'(direction);
    next_x   = head_x_q;
    next_y   = head_y_q;
    wall_hit = 1'b0;
    unique case (eff_dir)
      DIR_UP: begin
        wall_hit = (head_y_q == '0);
        next_y   = head_y_q - 7'd1;
      end
      DIR_DOWN: begin
        wall_hit = (head_y_q == COORD_W'(Y_BLOCKS - 1));
        next_y   = head_y_q + 7'd1;
      end
      DIR_RIGHT: begin
        wall_hit = (head_x_q == COORD_W'(X_BLOCKS - 1));
        next_x   = head_x_q + 7'd1;
      end
      DIR_LEFT: begin
        wall_hit = (head_x_q == '0);
        next_x   = head_x_q - 7'd1;
      end
    endcase
  end

`ifdef SNAKE_SELF_COLLISION_EN
  snake_collision_check #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) u_collision (
    .next_x       (next_x),
    .next_y       (next_y),
    .body_x       (body_x_q),
    .body_y       (body_y_q),
    .snake_length (len_q),
    .hit          (self_hit)
  );
`else
  assign self_hit = 1'b0;
`endif

  always_comb begin
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    body_x_d    = body_x_q;
    body_y_d    = body_y_q;
    len_d       = len_q;
    dir_d       = dir_q;
    grow_pend_d = grow_pend_q;
    game_over_d = game_over_q;
    grow_now    = grow_pend_q | grow;

    if (!game_over_q) begin
      grow_pend_d = grow_now;
      if (move_tick) begin
        if (wall_hit || self_hit) begin
          game_over_d = 1'b1;
        end else begin
          grow_pend_d = 1'b0;
          dir_d       = eff_dir;
          head_x_d    = next_x;
          head_y_d    = next_y;
          if (grow_now && (len_q < LEN_W'(SNAKE_LENGTH_MAX))) begin
            len_d = len_q + LEN_W'(1);
          end
          // Only entries below the new length receive real coordinates.
          body_x_d[0] = (len_d > LEN_W'(1)) ? head_x_q : SENTINEL;
          body_y_d[0] = (len_d > LEN_W'(1)) ? head_y_q : SENTINEL;
          for (int i = 1; i < DEPTH; i++) begin
            body_x_d[i] = (LEN_W'(i) < len_d - LEN_W'(1)) ? body_x_q[i-1] : SENTINEL;
            body_y_d[i] = (LEN_W'(i) < len_d - LEN_W'(1)) ? body_y_q[i-1] : SENTINEL;
          end
        end
      end
    end

    cnt_d   = (cnt_q == SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2)) ? '0 : cnt_q + 1'b1;
    // Stream the post-edge contents so each output pair matches its index.
    out_x_d = body_x_d[cnt_d];
    out_y_d = body_y_d[cnt_d];
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      head_x_q    <= COORD_W'(START_X);
      head_y_q    <= COORD_W'(START_Y);
      body_x_q    <= {DEPTH{SENTINEL}};
      body_y_q    <= {DEPTH{SENTINEL}};
      body_x_q[0] <= COORD_W'(START_X - 1);
      body_y_q[0] <= COORD_W'(START_Y);
      body_x_q[1] <= COORD_W'(START_X - 2);
      body_y_q[1] <= COORD_W'(START_Y);
      len_q       <= LEN_W'(3);
      dir_q       <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
      out_x_q     <= COORD_W'(START_X - 1);
      out_y_q     <= COORD_W'(START_Y);
    end else begin
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      body_x_q    <= body_x_d;
      body_y_q    <= body_y_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      grow_pend_q <= grow_pend_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign snake_head_x = head_x_q;
  assign snake_head_y = head_y_q;
  assign snake_body_x = out_x_q;
  assign snake_body_y = out_y_q;
  assign body_count   = cnt_q;
  assign snake_length = len_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Bench for snake_body_streamer: directed scenarios plus random moves/grows, checked every
// cycle against a segment-queue model of the snake.
module tb_snake_body_streamer;

  localparam int LMAX = 16;
  localparam int XB   = 124;
  localparam int YB   = 81;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_tick = 1'b0;
  logic [1:0] direction = 2'b10;
  logic       grow = 1'b0;
  logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
  logic [3:0] body_count;
  logic [4:0] snake_length;
  logic       game_over;

  int n_vec = 0;
  int n_err = 0;

  // Model: segment queues, index 0 is the head.
  int qx[$];
  int qy[$];
  int mdx, mdy, mcnt;
  bit mgp, mgo;

  snake_body_streamer dut (
    .clock_25     (clk),
    .reset        (reset),
    .move_tick    (move_tick),
    .direction    (direction),
    .grow         (grow),
    .snake_head_x (snake_head_x),
    .snake_head_y (snake_head_y),
    .snake_body_x (snake_body_x),
    .snake_body_y (snake_body_y),
    .body_count   (body_count),
    .snake_length (snake_length),
    .game_over    (game_over)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    qx = '{62, 61, 60};
    qy = '{40, 40, 40};
    mdx = 1; mdy = 0; mgp = 0; mgo = 0; mcnt = 0;
  endtask

  task automatic dir_vec(input logic [1:0] d, output int dx, output int dy);
    case (d)
      2'b00: begin dx = 0;  dy = -1; end
      2'b01: begin dx = 0;  dy = 1;  end
      2'b10: begin dx = 1;  dy = 0;  end
      default: begin dx = -1; dy = 0; end
    endcase
  endtask

  task automatic model_update(input logic m, input logic [1:0] d, input logic g);
    int dx, dy, nx, ny;
    bit gnow, hit;
    mcnt = (mcnt == LMAX - 2) ? 0 : mcnt + 1;
    if (mgo) return;
    gnow = mgp || g;
    mgp  = gnow;
    if (!m) return;
    dir_vec(d, dx, dy);
    if (dx == -mdx && dy == -mdy) begin
      dx = mdx; dy = mdy;
    end
    nx  = qx[0] + dx;
    ny  = qy[0] + dy;
    hit = (nx < 0) || (nx >= XB) || (ny < 0) || (ny >= YB);
`ifdef SNAKE_SELF_COLLISION_EN
    for (int j = 1; j <= qx.size() - 2; j++)
      if (qx[j] == nx && qy[j] == ny) hit = 1;
`endif
    if (hit) begin
      mgo = 1;
      return;
    end
    mdx = dx; mdy = dy; mgp = 0;
    qx.push_front(nx);
    qy.push_front(ny);
    if (!(gnow && qx.size() <= LMAX)) begin
      void'(qx.pop_back());
      void'(qy.pop_back());
    end
  endtask

  task automatic compare_all();
    int ex, ey;
    ex = (mcnt + 1 < qx.size()) ? qx[mcnt+1] : 127;
    ey = (mcnt + 1 < qy.size()) ? qy[mcnt+1] : 127;
    chk("head_x", snake_head_x, qx[0]);
    chk("head_y", snake_head_y, qy[0]);
    chk("length", snake_length, qx.size());
    chk("game_over", game_over, mgo);
    chk("body_count", body_count, mcnt);
    chk("body_x", snake_body_x, ex);
    chk("body_y", snake_body_y, ey);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic m, input logic [1:0] d, input logic g);
    move_tick = m; direction = d; grow = g;
    @(posedge clk);
    model_update(m, d, g);
    #1 compare_all();
    @(negedge clk);
  endtask

  // Reset asserted together with a move/grow request: the move must be aborted.
  task automatic do_reset();
    reset = 1'b1; move_tick = 1'b1; grow = 1'b1; direction = 2'b00;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0; move_tick = 1'b0; grow = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    repeat (16) step(1'b0, 2'b10, 1'b0);

    step(1'b1, 2'b10, 1'b0);
    chk("req039_head_x", snake_head_x, 63);

    do_reset();
    step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b00, 1'b0);
    chk("req040_head_y", snake_head_y, 39);
    chk("req040_len", snake_length, 4);

    do_reset();
    step(1'b1, 2'b11, 1'b0);
    chk("req041_head_x", snake_head_x, 63);

    do_reset();
    repeat (61) step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk("req042_go", game_over, 1);
    chk("req042_head_x", snake_head_x, 123);
    step(1'b1, 2'b00, 1'b1);
    repeat (20) step(1'b0, 2'b00, 1'b0);

    do_reset();
    repeat (20) step(1'b1, 2'b10, 1'b1);
    repeat (16) step(1'b0, 2'b10, 1'b0);
    chk("sat_len", snake_length, LMAX);

    do_reset();
    step(1'b1, 2'b10, 1'b1);
    step(1'b1, 2'b10, 1'b1);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    repeat (4) step(1'b0, 2'b00, 1'b0);

    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++)
        step(($urandom % 3) == 0, 2'($urandom), ($urandom % 6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_body_streamer.md
SNAKE_BODY_STREAMER -- requirements
Module: snake_body_streamer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 Parameter SNAKE_LENGTH_BIT, default 4: width of length and index buses.
REQ-003 Parameter SNAKE_LENGTH_MAX, default 16: segments including head; body array depth is SNAKE_LENGTH_MAX-1.
REQ-004 Parameters X_BLOCKS, default 124, and Y_BLOCKS, default 81: grid size in blocks.
REQ-005 Parameters START_X, default 62, and START_Y, default 40: head position after reset.
REQ-006 Port clock_25, input, 1 bit: 25 MHz clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port move_tick, input, 1 bit: single-cycle pulse that advances the snake one block.
REQ-009 Port direction, input, 2 bits: 00 up, 01 down, 10 right, 11 left.
REQ-010 Port grow, input, 1 bit: single-cycle pulse indicating fruit eaten.
REQ-011 Ports snake_head_x and snake_head_y, outputs, 7 bits each: head block coordinates.
REQ-012 Ports snake_body_x and snake_body_y, outputs, 7 bits each: coordinates of body entry body_count.
REQ-013 Port body_count, output, SNAKE_LENGTH_BIT bits: index of the streamed entry.
REQ-014 Port snake_length, output, SNAKE_LENGTH_BIT+1 bits: segments including head.
REQ-015 Port game_over, output, 1 bit: sticky flag for a wall hit or self-collision.

Function
REQ-016 Storage SHALL be head_x/head_y plus body[0..SNAKE_LENGTH_MAX-2]; body[0] is adjacent to the head and body[snake_length-2] is the tail.
REQ-017 On move_tick with game_over=0, the shift SHALL occur in one cycle: body[i]<=body[i-1] for i>=1, body[0]<=head, head<=head+step(dir_reg).
REQ-018 Steps SHALL be: up y-1, down y+1, right x+1, left x-1.
REQ-019 dir_reg SHALL load direction on move_tick, except that a direct reversal (up<->down or left<->right) SHALL be ignored and dir_reg kept.
REQ-020 A grow pulse SHALL set grow_pending.
REQ-021 grow_pending SHALL be consumed on the next move_tick, incrementing snake_length.
REQ-022 If grow and move_tick occur in the same cycle, the growth SHALL apply to that move.
REQ-023 snake_length SHALL saturate at SNAKE_LENGTH_MAX; at saturation grow_pending SHALL clear with no effect.
REQ-024 If the next head would leave the grid (x=0 moving left, x=X_BLOCKS-1 moving right, and likewise for y against Y_BLOCKS), the block SHALL set game_over and SHALL NOT move the head or body.
REQ-025 While game_over=1, move_tick and grow SHALL be ignored; game_over SHALL clear only on reset.
REQ-026 body_count SHALL increment every cycle from 0 to SNAKE_LENGTH_MAX-2 and then wrap to 0, independent of move_tick.
REQ-027 snake_body_x and snake_body_y SHALL be registered and SHALL update on the same edge as body_count, so that each coordinate pair matches its index (the downstream renderer writes entry [body_count] every edge).
REQ-028 Entries at index snake_length-1 and above SHALL hold sentinel 7'h7F.
REQ-029 A shift SHALL propagate real coordinates only into entries below the new snake_length; all other entries SHALL keep 7'h7F.
REQ-030 Head outputs SHALL be registered and SHALL be valid one cycle after the move_tick edge.

Reset
REQ-031 On reset: head=(START_X,START_Y), body[0]=(START_X-1,START_Y), body[1]=(START_X-2,START_Y), all other entries 7'h7F.
REQ-032 On reset: snake_length=3, dir_reg=right, grow_pending=0, game_over=0, body_count=0, snake_body_x/y=body[0].
REQ-033 Reset asserted mid-move SHALL abort the shift with no partial update.

Configuration
REQ-034 With SNAKE_SELF_COLLISION_EN defined, a move whose next head equals any body[i] for i<snake_length-2 SHALL set game_over and SHALL suppress the move; the tail entry is exempt because it vacates.
REQ-035 Without SNAKE_SELF_COLLISION_EN, no self-collision comparators SHALL exist and only wall hits SHALL set game_over.

Structure
REQ-036 Direction encodings, the 7'h7F sentinel, and grid constants SHALL live in the shared package snake_pkg.
REQ-037 The comparator bank SHALL be the sub-module snake_collision_check, instantiated only under SNAKE_SELF_COLLISION_EN.

Verification
REQ-038 Reset, then observe 15 cycles -> head (62,40), body_count 0..14 then 0, body (61,40),(60,40), then 7'h7F.
REQ-039 move_tick with direction=10 -> head (63,40), body[0]=(62,40), body[1]=(61,40), length 3.
REQ-040 grow, then move_tick with direction=00 -> head (62,39), length 4, body[2]=(60,40).
REQ-041 direction=11 while moving right, then move_tick -> head x+1 (reversal ignored).
REQ-042 Head at x=123 moving right, then move_tick -> game_over=1, positions frozen; a further move_tick has no effect.
REQ-043 With SNAKE_SELF_COLLISION_EN, a length-5 snake on a turn sequence right, down, left, up -> game_over=1 on the head-on-body move.
